// File: rtl/diff_engine.sv
// ----------------------------------------------------------------------------
// diff_engine
//   Third-order finite-difference polynomial generator. Each step folds every
//   difference column into the column above it (d0+=d1, d1+=d2, d2+=d3). Each
//   add uses the lower column's pre-step value. The value column d0 drives
//   the display multiplexer's binary input directly.
//
// Ports
//   clk            system clock, all state updates on posedge
//   rst_n          asynchronous active-low reset
//   load           1-cycle pulse: copy init0..init3 into d0..d3 (highest priority)
//   init0..init3   initial value, 1st, 2nd and constant 3rd difference
//   step           1-cycle pulse: advance one step (ignored while busy)
//   run            level: auto-step every RUN_DIV idle cycles
//   bin            current value column d0
//   busy           high while a step is in progress
//   ovf            sticky: a d0 result exceeded MAXVAL since the last load
//   count          completed steps since load, wraps 255->0
// ----------------------------------------------------------------------------
module diff_engine #(
    parameter int unsigned W       = 10,
    parameter int unsigned MAXVAL  = 999,
    parameter int unsigned RUN_DIV = 1000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] init0,
    input  logic [W-1:0] init1,
    input  logic [W-1:0] init2,
    input  logic [W-1:0] init3,
    input  logic         step,
    input  logic         run,
    output logic [W-1:0] bin,
    output logic         busy,
    output logic         ovf,
    output logic [7:0]   count
);

    localparam int unsigned TW = $clog2(RUN_DIV);
    localparam int unsigned CW = 8;

    localparam logic [TW-1:0] TIMER_LAST = TW'(RUN_DIV - 1);
    localparam logic [W-1:0]  MAX_V      = W'(MAXVAL);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD0 = 2'd1;
    localparam logic [1:0] ADD1 = 2'd2;
    localparam logic [1:0] ADD2 = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  d0_q, d0_d;
    logic [W-1:0]  d1_q, d1_d;
    logic [W-1:0]  d2_q, d2_d;
    logic [W-1:0]  d3_q, d3_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] timer_q, timer_d;

    logic          run_tick_c;
    logic          start_c;
    logic [W-1:0]  sum0_c;

    // Auto-step tick: timer only advances while idle with run high.
    assign run_tick_c = run && (state_q == IDLE) && (timer_q == TIMER_LAST);
    // A step pulse and a run tick in the same cycle merge into one start.
    assign start_c    = step || run_tick_c;
    // Truncated sum; ovf is judged on the W-bit result only.
    assign sum0_c     = d0_q + d1_q;

    // Next-state and column update logic.
    always_comb begin
        state_d = state_q;
        d0_d    = d0_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        d3_d    = d3_q;
        ovf_d   = ovf_q;
        count_d = count_q;
        timer_d = timer_q;

        if (load) begin
            state_d = IDLE;
            d0_d    = init0;
            d1_d    = init1;
            d2_d    = init2;
            d3_d    = init3;
            ovf_d   = 1'b0;
            count_d = '0;
            timer_d = '0;
        end else begin
            if (!run) begin
                timer_d = '0;
            end else if (state_q == IDLE) begin
                timer_d = run_tick_c ? '0 : timer_q + TW'(1);
            end

            case (state_q)
                IDLE: begin
                    if (start_c) begin
                        state_d = ADD0;
                    end
                end
                ADD0: begin
                    d0_d    = sum0_c;
                    ovf_d   = ovf_q | (sum0_c > MAX_V);
                    state_d = ADD1;
                end
                ADD1: begin
                    d1_d    = d1_q + d2_q;
                    state_d = ADD2;
                end
                ADD2: begin
                    d2_d    = d2_q + d3_q;
                    count_d = count_q + CW'(1);
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and column registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            d0_q    <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            d3_q    <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            d3_q    <= d3_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
            timer_q <= timer_d;
        end
    end

    // bin is the d0 register itself; busy decodes the state register.
    assign bin   = d0_q;
    assign busy  = (state_q != IDLE);
    assign ovf   = ovf_q;
    assign count = count_q;

endmodule

// File: tb/tb_diff_engine.sv
module tb_diff_engine;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [9:0] init0, init1, init2, init3;
    logic       step;
    logic       run;
    logic [9:0] bin;
    logic       busy;
    logic       ovf;
    logic [7:0] count;

    diff_engine #(.W(10), .MAXVAL(999), .RUN_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .init0 (init0),
        .init1 (init1),
        .init2 (init2),
        .init3 (init3),
        .step  (step),
        .run   (run),
        .bin   (bin),
        .busy  (busy),
        .ovf   (ovf),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] bin;
        logic [7:0] cnt;
        logic       ovf;
        logic [9:0] d1;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   squash   = 1'b0;
    int   edge_n   = 0;
    int   next_ok  = 0;

    // Reference model: the polynomial columns as plain arithmetic.
    logic [9:0] m0, m1, m2, m3;
    logic [7:0] mc;
    logic       mo;

    function automatic void chk(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    function automatic void model_step();
        logic [9:0] s0;
        s0 = 10'(m0 + m1);
        mo = mo | (int'(s0) > 999);
        m0 = s0;
        m1 = 10'(m1 + m2);
        m2 = 10'(m2 + m3);
        mc = 8'(mc + 8'd1);
    endfunction

    function automatic void push_step();
        exp_t e;
        model_step();
        e.bin = m0; e.cnt = mc; e.ovf = mo; e.d1 = m1;
        q.push_back(e);
    endfunction

    function automatic void model_clear();
        m0 = '0; m1 = '0; m2 = '0; m3 = '0; mc = '0; mo = 1'b0;
    endfunction

    // Monitor: a completed step shows up as busy falling.
    initial begin : monitor
        bit   busy_prev;
        exp_t e;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_prev && !busy) begin
                if (squash) begin
                    squash = 1'b0;
                end else if (q.size() == 0) begin
                    chk("unexpected_step", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("sb_bin",   int'(bin),      int'(e.bin));
                    chk("sb_count", int'(count),    int'(e.cnt));
                    chk("sb_ovf",   int'(ovf),      int'(e.ovf));
                    chk("sb_d1",    int'(dut.d1_q), int'(e.d1));
                end
            end
            busy_prev = busy;
        end
    end

    // One clock cycle of stimulus; inputs are sampled at the next posedge.
    task automatic cycle(input bit ld, input bit st, input bit rn);
        load = ld; step = st; run = rn;
        if (ld) begin
            if (edge_n < next_ok) begin
                if (q.size() > 0) void'(q.pop_back());
                squash = 1'b1;
            end
            m0 = init0; m1 = init1; m2 = init2; m3 = init3; mc = '0; mo = 1'b0;
            next_ok = edge_n + 1;
        end else if (st && edge_n >= next_ok) begin
            push_step();
            next_ok = edge_n + 4;
        end
        @(posedge clk);
        #1;
        edge_n++;
        load = 1'b0;
        step = 1'b0;
    endtask

    task automatic do_load(input logic [9:0] a, input logic [9:0] b,
                           input logic [9:0] c, input logic [9:0] d);
        init0 = a; init1 = b; init2 = c; init3 = d;
        cycle(1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_step();
        cycle(1'b0, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_bin"},   int'(bin),   0);
        chk({tag, "_busy"},  int'(busy),  0);
        chk({tag, "_ovf"},   int'(ovf),   0);
        chk({tag, "_count"}, int'(count), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int exp_bin;
        rst_n = 1'b1;
        load = 1'b0; step = 1'b0; run = 1'b0;
        init0 = '0; init1 = '0; init2 = '0; init3 = '0;
        model_clear();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("reset");

        // Squares
        do_load(10'd0, 10'd1, 10'd2, 10'd0);
        repeat (4) do_step();
        chk("t1_bin", int'(bin), 16);

        // Cubes
        do_load(10'd0, 10'd1, 10'd6, 10'd6);
        repeat (4) do_step();
        chk("t2_bin", int'(bin), 64);

        // Overflow and negative difference
        do_load(10'd990, 10'd10, 10'd0, 10'd0);
        do_step();
        chk("t3_ovf_set", int'(ovf), 1);
        do_load(10'd10, 10'd1023, 10'd0, 10'd0);
        chk("t3_ovf_clr", int'(ovf), 0);
        repeat (2) do_step();
        chk("t3_bin", int'(bin), 8);

        // Busy rules: re-pulses ignored, busy exactly 3 cycles
        do_load(10'd5, 10'd2, 10'd0, 10'd0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("t4_busy0", int'(busy), 1);
        chk("t4_bin0",  int'(bin),  5);
        cycle(1'b0, 1'b1, 1'b0);
        chk("t4_busy1", int'(busy), 1);
        chk("t4_bin1",  int'(bin),  7);
        cycle(1'b0, 1'b1, 1'b0);
        chk("t4_busy2", int'(busy), 1);
        cycle(1'b0, 1'b0, 1'b0);
        chk("t4_busy3", int'(busy), 0);
        chk("t4_count", int'(count), 1);
        cycle(1'b0, 1'b1, 1'b0);
        chk("t4_restart", int'(busy), 1);
        cycle(1'b0, 1'b0, 1'b0);
        do_load(10'd300, 10'd4, 10'd3, 10'd2);
        chk("t4_abort_busy",  int'(busy),  0);
        chk("t4_abort_bin",   int'(bin),   300);
        chk("t4_abort_count", int'(count), 0);
        do_step();

        // Run mode: ticks at edges 4, 11, 18, 25, 32, 39 after load
        do_load(10'd0, 10'd1, 10'd0, 10'd0);
        for (int k = 0; 4 + 7 * k <= 40; k++) push_step();
        for (int i = 1; i <= 40; i++) begin
            cycle(1'b0, 1'b0, 1'b1);
            exp_bin = (i >= 5) ? (i - 5) / 7 + 1 : 0;
            chk("t5_bin", int'(bin), exp_bin);
        end
        repeat (20) cycle(1'b0, 1'b0, 1'b0);
        chk("t5_frozen", int'(bin), 6);
        next_ok = edge_n;

        // Async reset in ADD1
        do_load(10'd100, 10'd3, 10'd2, 10'd1);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        if (q.size() > 0) void'(q.pop_back());
        squash = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk_zero("t6_async");
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        edge_n += 2;
        model_clear();
        next_ok = edge_n;
        do_step();
        chk("t6_bin", int'(bin), 0);

        // Randomized loads and steps, including load+step and step while busy
        for (int n = 0; n < 500; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 5) begin
                init0 = 10'($urandom); init1 = 10'($urandom);
                init2 = 10'($urandom); init3 = 10'($urandom);
                cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            end else begin
                cycle(1'b0, r < 45, 1'b0);
            end
        end
        repeat (6) cycle(1'b0, 1'b0, 1'b0);
        chk("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
